// File: rtl/ISO14443A_pkg.sv
// Shared ISO/IEC 14443-A definitions: PCD->PICC modified-Miller sequence
// codes, frame-layer widths and the odd-parity helper.
package ISO14443A_pkg;

  // Sequence symbols delivered by sequence_decode
  typedef enum logic [1:0] {
    PCDBitSequence_X     = 2'd0,
    PCDBitSequence_Y     = 2'd1,
    PCDBitSequence_Z     = 2'd2,
    PCDBitSequence_ERROR = 2'd3
  } PCDBitSequence;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DATA_BITS_W   = 3;
  // Holds 0..8: data bits committed so far; 8 means the parity bit is next
  localparam int unsigned BIT_CNT_W     = 4;
  localparam int unsigned BITS_PER_BYTE = 8;

  // True when the 8 data bits plus the parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/iso14443a_frame_decoder.sv
// ISO/IEC 14443-A PCD->PICC frame decoder.
// Turns modified-Miller sequences (X/Y/Z/ERROR) into SOC, LSb-first data
// bytes with odd parity checked and stripped, partial tail bytes, EOC and
// error pulses. Every output is registered; events appear one cycle after
// the sd_seq_valid sample.
// Optional: define FRAME_DECODE_SVA_EN to enable embedded protocol assertions.
module iso14443a_frame_decoder
  import ISO14443A_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  PCDBitSequence          sd_seq,
  input  logic                   sd_seq_valid,
  output logic                   soc,
  output logic                   eoc,
  output logic [BYTE_W-1:0]      data,
  output logic [DATA_BITS_W-1:0] data_bits,
  output logic                   data_valid,
  output logic                   sequence_error,
  output logic                   parity_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_prev_zero;   // last decoded bit (or SOC) was logic 0
  logic                   r_pend;        // decoded bit awaiting commit
  logic                   r_pend_vld;
  logic [BYTE_W-1:0]      r_byte;        // bits committed to the current byte
  logic [BIT_CNT_W-1:0]   r_cnt;         // committed bits in the current byte
  logic                   r_frame_bits;  // at least one bit committed this frame

  state_t                 w_state_nxt;
  logic                   w_prev_zero_nxt;
  logic                   w_pend_nxt;
  logic                   w_pend_vld_nxt;
  logic [BYTE_W-1:0]      w_byte_nxt;
  logic [BIT_CNT_W-1:0]   w_cnt_nxt;
  logic                   w_frame_bits_nxt;
  logic                   w_soc_nxt;
  logic                   w_eoc_nxt;
  logic [BYTE_W-1:0]      w_data_nxt;
  logic [DATA_BITS_W-1:0] w_data_bits_nxt;
  logic                   w_dv_nxt;
  logic                   w_se_nxt;
  logic                   w_pe_nxt;

  logic                   w_is_bit;
  logic                   w_bit;
  logic                   w_is_eoc;
  logic                   w_is_err;

  // Classify the incoming sequence against the previous logic level
  always_comb begin
    w_is_bit = 1'b0;
    w_bit    = 1'b0;
    w_is_eoc = 1'b0;
    w_is_err = 1'b0;
    if (sd_seq_valid) begin
      unique case (sd_seq)
        PCDBitSequence_X: begin
          w_is_bit = 1'b1;
          w_bit    = 1'b1;
        end
        PCDBitSequence_Z: begin
          w_is_bit = 1'b1;
          w_bit    = 1'b0;
        end
        PCDBitSequence_Y: begin
          // Y after a 0 cannot be data, so it marks end of communication
          if (r_prev_zero) begin
            w_is_eoc = 1'b1;
          end else begin
            w_is_bit = 1'b1;
            w_bit    = 1'b0;
          end
        end
        PCDBitSequence_ERROR: begin
          w_is_err = 1'b1;
        end
      endcase
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_zero_nxt  = r_prev_zero;
    w_pend_nxt       = r_pend;
    w_pend_vld_nxt   = r_pend_vld;
    w_byte_nxt       = r_byte;
    w_cnt_nxt        = r_cnt;
    w_frame_bits_nxt = r_frame_bits;
    w_soc_nxt        = 1'b0;
    w_eoc_nxt        = 1'b0;
    w_dv_nxt         = 1'b0;
    w_se_nxt         = 1'b0;
    w_pe_nxt         = 1'b0;
    w_data_nxt       = data;
    w_data_bits_nxt  = data_bits;

    case (r_state)
      ST_IDLE: begin
        // Only Z opens a frame; SOC acts as a logic 0 for the next Y
        if (sd_seq_valid && (sd_seq == PCDBitSequence_Z)) begin
          w_soc_nxt        = 1'b1;
          w_state_nxt      = ST_DATA;
          w_prev_zero_nxt  = 1'b1;
          w_pend_vld_nxt   = 1'b0;
          w_byte_nxt       = '0;
          w_cnt_nxt        = '0;
          w_frame_bits_nxt = 1'b0;
        end
      end

      ST_DATA: begin
        if (w_is_eoc) begin
          // Pending bit is the EOC's leading 0 and is dropped
          w_eoc_nxt       = 1'b1;
          w_state_nxt     = ST_IDLE;
          w_pend_vld_nxt  = 1'b0;
          w_data_bits_nxt = '0;
          if (!r_frame_bits) begin
            w_se_nxt = 1'b1;
          end else if (r_cnt == BIT_CNT_W'(BITS_PER_BYTE)) begin
            w_pe_nxt = 1'b1;
          end else if (r_cnt != '0) begin
            w_dv_nxt        = 1'b1;
            w_data_nxt      = r_byte;
            w_data_bits_nxt = DATA_BITS_W'(r_cnt);
          end
        end else if (w_is_bit) begin
          // A new bit proves the pending one was data: commit it
          if (r_pend_vld) begin
            w_frame_bits_nxt = 1'b1;
            if (r_cnt < BIT_CNT_W'(BITS_PER_BYTE)) begin
              w_byte_nxt[r_cnt[DATA_BITS_W-1:0]] = r_pend;
              w_cnt_nxt = r_cnt + BIT_CNT_W'(1);
            end else if (odd_parity_ok(r_byte, r_pend)) begin
              w_dv_nxt        = 1'b1;
              w_data_nxt      = r_byte;
              w_data_bits_nxt = '0;
              w_byte_nxt      = '0;
              w_cnt_nxt       = '0;
            end else begin
              w_pe_nxt    = 1'b1;
              w_state_nxt = ST_ERR;
            end
          end
          w_pend_nxt      = w_bit;
          w_pend_vld_nxt  = 1'b1;
          w_prev_zero_nxt = ~w_bit;
        end else if (w_is_err) begin
          w_se_nxt    = 1'b1;
          w_state_nxt = ST_ERR;
        end
      end

      ST_ERR: begin
        // Discard the rest of the frame, only watching for its EOC
        if (w_is_eoc) begin
          w_eoc_nxt       = 1'b1;
          w_data_bits_nxt = '0;
          w_state_nxt     = ST_IDLE;
        end else if (w_is_bit) begin
          w_prev_zero_nxt = ~w_bit;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_prev_zero    <= 1'b0;
      r_pend         <= 1'b0;
      r_pend_vld     <= 1'b0;
      r_byte         <= '0;
      r_cnt          <= '0;
      r_frame_bits   <= 1'b0;
      soc            <= 1'b0;
      eoc            <= 1'b0;
      data           <= '0;
      data_bits      <= '0;
      data_valid     <= 1'b0;
      sequence_error <= 1'b0;
      parity_error   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_prev_zero    <= w_prev_zero_nxt;
      r_pend         <= w_pend_nxt;
      r_pend_vld     <= w_pend_vld_nxt;
      r_byte         <= w_byte_nxt;
      r_cnt          <= w_cnt_nxt;
      r_frame_bits   <= w_frame_bits_nxt;
      soc            <= w_soc_nxt;
      eoc            <= w_eoc_nxt;
      data           <= w_data_nxt;
      data_bits      <= w_data_bits_nxt;
      data_valid     <= w_dv_nxt;
      sequence_error <= w_se_nxt;
      parity_error   <= w_pe_nxt;
    end
  end

`ifdef FRAME_DECODE_SVA_EN
  // Output pulses are single-cycle
  a_soc_pulse: assert property (@(posedge clk) disable iff (rst) soc |=> !soc);
  a_eoc_pulse: assert property (@(posedge clk) disable iff (rst) eoc |=> !eoc);
  a_dv_pulse:  assert property (@(posedge clk) disable iff (rst) data_valid |=> !data_valid);
  a_se_pulse:  assert property (@(posedge clk) disable iff (rst) sequence_error |=> !sequence_error);
  a_pe_pulse:  assert property (@(posedge clk) disable iff (rst) parity_error |=> !parity_error);
  // Mutually exclusive events
  a_soc_eoc:   assert property (@(posedge clk) disable iff (rst) !(soc && eoc));
  a_dv_pe:     assert property (@(posedge clk) disable iff (rst) !(data_valid && parity_error));
  // Partial bytes are only reported together with EOC
  a_bits_eoc:  assert property (@(posedge clk) disable iff (rst)
                                (data_valid && !eoc) |-> (data_bits == '0));
`endif

endmodule

// File: tb/tb_iso14443a_frame_decoder.sv
// Directed and random bench for iso14443a_frame_decoder with an event scoreboard.
module tb_iso14443a_frame_decoder;
  import ISO14443A_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  PCDBitSequence sd_seq;
  logic          sd_seq_valid;
  logic          soc, eoc, data_valid, sequence_error, parity_error;
  logic [7:0]    data;
  logic [2:0]    data_bits;

  iso14443a_frame_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .sd_seq         (sd_seq),
    .sd_seq_valid   (sd_seq_valid),
    .soc            (soc),
    .eoc            (eoc),
    .data           (data),
    .data_bits      (data_bits),
    .data_valid     (data_valid),
    .sequence_error (sequence_error),
    .parity_error   (parity_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       soc;
    logic       eoc;
    logic       dv;
    logic       se;
    logic       pe;
    logic [7:0] data;
    logic [2:0] bits;
    logic       chk_bits;
  } ev_t;

  ev_t exp_q[$];
  bit  tx_bits[$];
  bit  enc_prev_one;
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_ev(input logic s, input logic e, input logic dv, input logic se,
                         input logic pe, input logic [7:0] d, input logic [2:0] b,
                         input logic cb);
    ev_t ev;
    ev.soc = s; ev.eoc = e; ev.dv = dv; ev.se = se; ev.pe = pe;
    ev.data = d; ev.bits = b; ev.chk_bits = cb;
    exp_q.push_back(ev);
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and scored
  task automatic tick();
    ev_t ev;
    @(posedge clk);
    #1;
    if (soc || eoc || data_valid || sequence_error || parity_error) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'({soc, eoc, data_valid, sequence_error, parity_error}), 32'd0);
      end else begin
        ev = exp_q.pop_front();
        chk("pulses{soc,eoc,dv,se,pe}",
            32'({soc, eoc, data_valid, sequence_error, parity_error}),
            32'({ev.soc, ev.eoc, ev.dv, ev.se, ev.pe}));
        if (ev.dv) begin
          chk("data", 32'(data), 32'(ev.data));
          chk("data_bits", 32'(data_bits), 32'(ev.bits));
        end else if (ev.chk_bits) begin
          chk("data_bits_zero", 32'(data_bits), 32'd0);
        end
      end
    end
  endtask

  // One sequence strobe, sometimes followed by an idle cycle carrying junk
  task automatic send_seq(input PCDBitSequence s);
    sd_seq       = s;
    sd_seq_valid = 1'b1;
    tick();
    sd_seq_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      sd_seq = PCDBitSequence'($urandom_range(0, 3));
      tick();
    end
  endtask

  // Modified-Miller encoding of one logic bit
  task automatic enc_bit(input bit b);
    if (b) begin
      send_seq(PCDBitSequence_X);
      enc_prev_one = 1'b1;
    end else begin
      send_seq(enc_prev_one ? PCDBitSequence_Y : PCDBitSequence_Z);
      enc_prev_one = 1'b0;
    end
  endtask

  task automatic send_eoc();
    enc_bit(1'b0);
    send_seq(PCDBitSequence_Y);
  endtask

  // SOC, all of tx_bits, then EOC
  task automatic send_frame();
    send_seq(PCDBitSequence_Z);
    enc_prev_one = 1'b0;
    foreach (tx_bits[i]) enc_bit(tx_bits[i]);
    send_eoc();
    repeat (3) tick();
  endtask

  task automatic push_byte(input logic [7:0] b, input bit bad_parity);
    for (int j = 0; j < 8; j++) tx_bits.push_back(b[j]);
    tx_bits.push_back((~^b) ^ bad_parity);
  endtask

  // Well-formed frame of n data bits with expected events queued
  task automatic load_good(input int n);
    logic [7:0] b;
    int nb;
    int k;
    nb = n / 8;
    k  = n % 8;
    tx_bits.delete();
    push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
    for (int i = 0; i < nb; i++) begin
      b = 8'($urandom);
      push_byte(b, 1'b0);
      push_ev(0, 0, 1, 0, 0, b, 3'd0, 0);
    end
    b = 8'h00;
    for (int j = 0; j < k; j++) begin
      b[j] = 1'($urandom);
      tx_bits.push_back(b[j]);
    end
    if (k > 0) push_ev(0, 1, 1, 0, 0, b, 3'(k), 0);
    else       push_ev(0, 1, 0, 0, 0, 8'h00, 3'd0, 1);
  endtask

  PCDBitSequence s29[12];
  logic [7:0]    rb;

  initial begin
    rst          = 1'b1;
    sd_seq       = PCDBitSequence_X;
    sd_seq_valid = 1'b0;
    repeat (3) tick();
    chk("rst_soc", 32'(soc), 32'd0);
    chk("rst_eoc", 32'(eoc), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_se", 32'(sequence_error), 32'd0);
    chk("rst_pe", 32'(parity_error), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_data_bits", 32'(data_bits), 32'd0);
    rst = 1'b0;
    tick();

    // X/Y/ERROR in IDLE are ignored
    send_seq(PCDBitSequence_X);
    send_seq(PCDBitSequence_Y);
    send_seq(PCDBitSequence_ERROR);

    // Directed byte 0x29 with parity 0
    s29 = '{PCDBitSequence_Z, PCDBitSequence_X, PCDBitSequence_Y, PCDBitSequence_Z,
            PCDBitSequence_X, PCDBitSequence_Y, PCDBitSequence_X, PCDBitSequence_Y,
            PCDBitSequence_Z, PCDBitSequence_Z, PCDBitSequence_Z, PCDBitSequence_Y};
    push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
    push_ev(0, 0, 1, 0, 0, 8'h29, 3'd0, 0);
    push_ev(0, 1, 0, 0, 0, 8'h00, 3'd0, 1);
    foreach (s29[i]) send_seq(s29[i]);
    repeat (3) tick();

    // Random byte with flipped parity
    rb = 8'($urandom);
    tx_bits.delete();
    push_byte(rb, 1'b1);
    push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
    push_ev(0, 0, 0, 0, 1, 8'h00, 3'd0, 0);
    push_ev(0, 1, 0, 0, 0, 8'h00, 3'd0, 1);
    send_frame();

    // Eight data bits, parity missing
    rb = 8'($urandom);
    tx_bits.delete();
    for (int j = 0; j < 8; j++) tx_bits.push_back(rb[j]);
    push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
    push_ev(0, 1, 0, 0, 1, 8'h00, 3'd0, 0);
    send_frame();

    // ERROR replacing bit position p of a one-byte frame
    for (int p = 1; p <= 9; p++) begin
      rb = 8'($urandom);
      tx_bits.delete();
      push_byte(rb, 1'b0);
      push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
      push_ev(0, 0, 0, 1, 0, 8'h00, 3'd0, 0);
      push_ev(0, 1, 0, 0, 0, 8'h00, 3'd0, 1);
      send_seq(PCDBitSequence_Z);
      enc_prev_one = 1'b0;
      for (int i = 0; i < p - 1; i++) enc_bit(tx_bits[i]);
      send_seq(PCDBitSequence_ERROR);
      send_seq(PCDBitSequence_Z);
      send_seq(PCDBitSequence_Y);
      repeat (2) tick();
    end

    // Empty frames: Z,Y,Y and Z,Z,Y
    push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
    push_ev(0, 1, 0, 1, 0, 8'h00, 3'd0, 1);
    send_seq(PCDBitSequence_Z);
    send_seq(PCDBitSequence_Y);
    send_seq(PCDBitSequence_Y);
    push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
    push_ev(0, 1, 0, 1, 0, 8'h00, 3'd0, 1);
    send_seq(PCDBitSequence_Z);
    send_seq(PCDBitSequence_Z);
    send_seq(PCDBitSequence_Y);
    repeat (2) tick();

    // Three-bit frame 1,0,1
    tx_bits.delete();
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
    push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
    push_ev(0, 1, 1, 0, 0, 8'h05, 3'd3, 0);
    send_frame();

    // Every partial length 1..7
    for (int n = 1; n <= 7; n++) begin
      load_good(n);
      send_frame();
    end

    // Reset mid-frame: no EOC, outputs cleared
    push_ev(1, 0, 0, 0, 0, 8'h00, 3'd0, 0);
    sd_seq = PCDBitSequence_Z;
    sd_seq_valid = 1'b1;
    tick();
    sd_seq = PCDBitSequence_X;
    tick();
    sd_seq = PCDBitSequence_Y;
    tick();
    sd_seq_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_data_bits", 32'(data_bits), 32'd0);
    sd_seq = PCDBitSequence_Y;
    sd_seq_valid = 1'b1;
    tick();
    sd_seq_valid = 1'b0;
    rst = 1'b0;
    tick();
    // Y after reset must not end a frame that no longer exists
    send_seq(PCDBitSequence_Y);
    load_good(16);
    send_frame();

    // Random long frames
    for (int f = 0; f < 5; f++) begin
      load_good(int'($urandom_range(1, 1000)));
      send_frame();
    end

    repeat (5) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
